// File: rtl/execute_stage_pkg.sv
// Shared definitions for the decode/execute boundary: widths, opcodes, FSM
// states and the write-back payload. Optional macro: VENUS_EXEC_DIV_EN.
package execute_stage_pkg;

    localparam int unsigned WORD    = 32;
    localparam int unsigned W_OPC   = 7;
    localparam int unsigned W_OPR   = WORD;
    localparam int unsigned W_RD    = 4;
    localparam int unsigned MUL_CYC = W_OPR;
    localparam int unsigned W_CNT   = $clog2(MUL_CYC + 1);

    localparam logic [W_OPC-1:0] OPC_ADD  = 7'h00;
    localparam logic [W_OPC-1:0] OPC_SUB  = 7'h01;
    localparam logic [W_OPC-1:0] OPC_AND  = 7'h02;
    localparam logic [W_OPC-1:0] OPC_OR   = 7'h03;
    localparam logic [W_OPC-1:0] OPC_XOR  = 7'h04;
    localparam logic [W_OPC-1:0] OPC_SLL  = 7'h05;
    localparam logic [W_OPC-1:0] OPC_SRL  = 7'h06;
    localparam logic [W_OPC-1:0] OPC_SRA  = 7'h07;
    localparam logic [W_OPC-1:0] OPC_MOV  = 7'h08;
    localparam logic [W_OPC-1:0] OPC_MUL  = 7'h09;
    localparam logic [W_OPC-1:0] OPC_DIVU = 7'h0A;
    localparam logic [W_OPC-1:0] OPC_NOP  = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } exec_state_e;

    // Write-back payload presented to the register-file path.
    typedef struct packed {
        logic              v;
        logic [W_OPR-1:0]  result;
        logic              wb;
        logic [W_RD-1:0]   wb_r;
    } exec_out_t;

endpackage

// File: rtl/execute_stage_seq_muldiv.sv
// Iterative shift-add multiplier (and restoring divider when
// VENUS_EXEC_DIV_EN is defined). One step per cycle, MUL_CYC steps.
// o_next_c is the value after the step in progress, so the final step can
// be consumed directly at the completion edge; o_res_c is the settled value.
module execute_stage_seq_muldiv
    import execute_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
`ifdef VENUS_EXEC_DIV_EN
    input  logic             i_div,
`endif
    input  logic [W_OPR-1:0] i_opr0,
    input  logic [W_OPR-1:0] i_opr1,
    output logic             o_done_c,
    output logic [W_OPR-1:0] o_next_c,
    output logic [W_OPR-1:0] o_res_c
);

    logic [W_OPR-1:0] r_acc;
    logic [W_OPR-1:0] r_a;
    logic [W_OPR-1:0] r_b;
    logic [W_CNT-1:0] r_cnt;

    logic [W_OPR-1:0] w_mul_acc;
    logic [W_OPR-1:0] w_mul_a;
    logic [W_OPR-1:0] w_mul_b;
    logic [W_OPR-1:0] w_acc_n;
    logic [W_OPR-1:0] w_a_n;
    logic [W_OPR-1:0] w_b_n;

    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);
    assign w_mul_a   = {r_a[W_OPR-2:0], 1'b0};
    assign w_mul_b   = {1'b0, r_b[W_OPR-1:1]};

`ifdef VENUS_EXEC_DIV_EN
    logic           r_div;
    logic [W_OPR:0] w_rem_sh;
    logic           w_ge;
    logic [W_OPR-1:0] w_div_acc;
    logic [W_OPR-1:0] w_div_b;

    // Restoring division: acc is the partial remainder, b shifts the
    // dividend out and the quotient in, a holds the divisor. A zero divisor
    // always subtracts and yields an all-ones quotient.
    assign w_rem_sh  = {r_acc, r_b[W_OPR-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_a});
    assign w_div_acc = w_ge ? W_OPR'(w_rem_sh - {1'b0, r_a}) : W_OPR'(w_rem_sh);
    assign w_div_b   = {r_b[W_OPR-2:0], w_ge};

    assign w_acc_n  = r_div ? w_div_acc : w_mul_acc;
    assign w_a_n    = r_div ? r_a       : w_mul_a;
    assign w_b_n    = r_div ? w_div_b   : w_mul_b;
    assign o_next_c = r_div ? w_div_b   : w_mul_acc;
    assign o_res_c  = r_div ? r_b       : r_acc;
`else
    assign w_acc_n  = w_mul_acc;
    assign w_a_n    = w_mul_a;
    assign w_b_n    = w_mul_b;
    assign o_next_c = w_mul_acc;
    assign o_res_c  = r_acc;
`endif

    assign o_done_c = (r_cnt == W_CNT'(1));

    // Operand load on start, then one iteration per cycle until the counter empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
`ifdef VENUS_EXEC_DIV_EN
            r_div <= 1'b0;
`endif
        end else if (i_start) begin
            r_acc <= '0;
            r_cnt <= W_CNT'(MUL_CYC);
`ifdef VENUS_EXEC_DIV_EN
            r_div <= i_div;
            r_a   <= i_div ? i_opr1 : i_opr0;
            r_b   <= i_div ? i_opr0 : i_opr1;
`else
            r_a   <= i_opr0;
            r_b   <= i_opr1;
`endif
        end else if (r_cnt != '0) begin
            r_acc <= w_acc_n;
            r_a   <= w_a_n;
            r_b   <= w_b_n;
            r_cnt <= r_cnt - W_CNT'(1);
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative MUL (and DIVU when
// VENUS_EXEC_DIV_EN is defined), registered write-back outputs and a
// stall back to decode.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic             stall_i,
    output logic             stall_o,
    input  logic [W_OPC-1:0] opecode_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic [W_RD-1:0]  wb_r_i,
    output logic             v_o,
    output logic [W_OPR-1:0] result_o,
    output logic             wb_o,
    output logic [W_RD-1:0]  wb_r_o
);

    exec_state_e      r_state;
    exec_state_e      w_state_n;
    exec_out_t        r_out;
    exec_out_t        w_out_n;
    logic             w_load;
    logic             w_start;
    logic [W_RD-1:0]  r_wb_r_lat;

    logic             w_busy;
    logic             w_free;
    logic             w_accept;
    logic             w_is_seq;
    logic [W_OPR-1:0] w_alu_res;
    logic             w_alu_wb;
    logic             w_md_done;
    logic [W_OPR-1:0] w_md_next;
    logic [W_OPR-1:0] w_md_res;

    assign w_busy   = (r_state != ST_IDLE);
    assign w_free   = ~(stall_i & r_out.v);
    assign stall_o  = w_busy | (stall_i & r_out.v);
    assign w_accept = v_i & ~stall_o;

    assign v_o      = r_out.v;
    assign result_o = r_out.result;
    assign wb_o     = r_out.wb;
    assign wb_r_o   = r_out.wb_r;

`ifdef VENUS_EXEC_DIV_EN
    logic w_is_div;
    assign w_is_div = (opecode_i == OPC_DIVU);
    assign w_is_seq = (opecode_i == OPC_MUL) | w_is_div;
`else
    assign w_is_seq = (opecode_i == OPC_MUL);
`endif

    // Single-cycle ALU; undefined opcodes (and NOP) give result 0, no write-back.
    always_comb begin
        w_alu_res = '0;
        w_alu_wb  = 1'b1;
        case (opecode_i)
            OPC_ADD: w_alu_res = opr0_i + opr1_i;
            OPC_SUB: w_alu_res = opr0_i - opr1_i;
            OPC_AND: w_alu_res = opr0_i & opr1_i;
            OPC_OR:  w_alu_res = opr0_i | opr1_i;
            OPC_XOR: w_alu_res = opr0_i ^ opr1_i;
            OPC_SLL: w_alu_res = opr0_i << opr1_i[4:0];
            OPC_SRL: w_alu_res = opr0_i >> opr1_i[4:0];
            OPC_SRA: w_alu_res = W_OPR'($signed(opr0_i) >>> opr1_i[4:0]);
            OPC_MOV: w_alu_res = opr1_i;
            default: w_alu_wb  = 1'b0;
        endcase
    end

    execute_stage_seq_muldiv u_seq_muldiv (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_start),
`ifdef VENUS_EXEC_DIV_EN
        .i_div    (w_is_div),
`endif
        .i_opr0   (opr0_i),
        .i_opr1   (opr1_i),
        .o_done_c (w_md_done),
        .o_next_c (w_md_next),
        .o_res_c  (w_md_res)
    );

    // Next state and output-register load decision.
    // Accepting a multi-cycle op leaves the outputs untouched; the first
    // free edge in RUN then loads a bubble.
    always_comb begin
        w_state_n = r_state;
        w_load    = 1'b0;
        w_start   = 1'b0;
        w_out_n   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_seq) begin
                    w_start   = 1'b1;
                    w_state_n = ST_RUN;
                end else if (w_accept) begin
                    w_load         = 1'b1;
                    w_out_n.v      = 1'b1;
                    w_out_n.result = w_alu_res;
                    w_out_n.wb     = w_alu_wb;
                    w_out_n.wb_r   = wb_r_i;
                end else if (w_free) begin
                    w_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_md_done && w_free) begin
                    w_load         = 1'b1;
                    w_out_n.v      = 1'b1;
                    w_out_n.result = w_md_next;
                    w_out_n.wb     = 1'b1;
                    w_out_n.wb_r   = r_wb_r_lat;
                    w_state_n      = ST_IDLE;
                end else if (w_md_done) begin
                    w_state_n = ST_HOLD;
                end else if (w_free) begin
                    w_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_free) begin
                    w_load         = 1'b1;
                    w_out_n.v      = 1'b1;
                    w_out_n.result = w_md_res;
                    w_out_n.wb     = 1'b1;
                    w_out_n.wb_r   = r_wb_r_lat;
                    w_state_n      = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // State, latched destination and write-back output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_out      <= '0;
            r_wb_r_lat <= '0;
        end else begin
            r_state <= w_state_n;
            if (w_load) begin
                r_out <= w_out_n;
            end
            if (w_start) begin
                r_wb_r_lat <= wb_r_i;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expected write-backs are queued when
// an instruction is accepted and popped when the stage presents a new result.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             v_i;
    logic             stall_i;
    logic             stall_o;
    logic [W_OPC-1:0] opecode_i;
    logic [W_OPR-1:0] opr0_i;
    logic [W_OPR-1:0] opr1_i;
    logic [W_RD-1:0]  wb_r_i;
    logic             v_o;
    logic [W_OPR-1:0] result_o;
    logic             wb_o;
    logic [W_RD-1:0]  wb_r_o;

    typedef struct {
        logic [31:0] res;
        logic        wb;
        logic [3:0]  rd;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   loaded = 1'b0;
    bit   no_lat = 1'b0;
    int   waits;

    execute_stage dut (
        .clk       (clk),
        .reset     (reset),
        .v_i       (v_i),
        .stall_i   (stall_i),
        .stall_o   (stall_o),
        .opecode_i (opecode_i),
        .opr0_i    (opr0_i),
        .opr1_i    (opr1_i),
        .wb_r_i    (wb_r_i),
        .v_o       (v_o),
        .result_o  (result_o),
        .wb_o      (wb_o),
        .wb_r_o    (wb_r_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_seq_f(input logic [6:0] op);
`ifdef VENUS_EXEC_DIV_EN
        return (op == 7'h09) || (op == 7'h0A);
`else
        return (op == 7'h09);
`endif
    endfunction

    function automatic void model(input logic [6:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic wb);
        r  = '0;
        wb = 1'b1;
        case (op)
            7'h00: r = a + b;
            7'h01: r = a - b;
            7'h02: r = a & b;
            7'h03: r = a | b;
            7'h04: r = a ^ b;
            7'h05: r = a << b[4:0];
            7'h06: r = a >> b[4:0];
            7'h07: r = $signed(a) >>> b[4:0];
            7'h08: r = b;
            7'h09: r = a * b;
`ifdef VENUS_EXEC_DIV_EN
            7'h0A: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
`endif
            default: wb = 1'b0;
        endcase
    endfunction

    // Pops one expectation each time the outputs were freshly loaded with a valid result.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            loaded = 1'b0;
        end else begin
            if (v_o && loaded) begin
                if (sbq.size() == 0) begin
                    check("unexpected_out", {32'd0, result_o}, 64'hDEAD);
                end else begin
                    e = sbq.pop_front();
                    check("result", {32'd0, result_o}, {32'd0, e.res});
                    check("wb", {63'd0, wb_o}, {63'd0, e.wb});
                    check("wb_r", {60'd0, wb_r_o}, {60'd0, e.rd});
                    if (e.cyc >= 0) check("latency", 64'(cyc), 64'(e.cyc));
                end
            end
            loaded = !(stall_i && v_o) && !(v_i && !stall_o && is_seq_f(opecode_i));
        end
    end

    // Present one instruction (called at posedge+1) and wait for acceptance.
    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd, output int nwait);
        logic [31:0] r;
        logic        wb;
        bit          ok;
        exp_t        e;
        v_i = 1'b1; opecode_i = op; opr0_i = a; opr1_i = b; wb_r_i = rd;
        nwait = 0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!stall_o) ok = 1'b1;
            else begin
                nwait++;
                @(posedge clk); #1;
            end
        end
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
            v_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model(op, a, b, r, wb);
        e.res = r; e.wb = wb; e.rd = rd;
        e.cyc = no_lat ? -1 : cyc + (is_seq_f(op) ? 32 : 0);
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        v_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_v"}, {63'd0, v_o}, 64'd0);
        check({tag, "_res"}, {32'd0, result_o}, 64'd0);
        check({tag, "_wb"}, {63'd0, wb_o}, 64'd0);
        check({tag, "_wbr"}, {60'd0, wb_r_o}, 64'd0);
        check({tag, "_stall"}, {63'd0, stall_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; v_i = 1'b0; stall_i = 1'b0;
        opecode_i = '0; opr0_i = '0; opr1_i = '0; wb_r_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        reset = 1'b0;

        // Back-to-back single-cycle ops, no stall expected.
        issue(OPC_SUB, 32'd5, 32'd7, 4'd1, waits);
        check("b2b_sub_wait", 64'(waits), 64'd0);
        issue(OPC_SRA, 32'h8000_0000, 32'd4, 4'd2, waits);
        check("b2b_sra_wait", 64'(waits), 64'd0);
        issue(OPC_MOV, 32'd0, 32'h1234, 4'd5, waits);
        check("b2b_mov_wait", 64'(waits), 64'd0);
        issue(OPC_SLL, 32'h0000_0003, 32'hFFFF_FFE1, 4'd6, waits);
        issue(OPC_XOR, 32'hF0F0_0000, 32'h0FF0_FFFF, 4'd7, waits);
        idle(3);

        // MUL: 32 stall cycles, then the held ADD is accepted.
        issue(OPC_ADD, 32'd1, 32'd2, 4'd7, waits);
        issue(OPC_MUL, 32'h0001_0000, 32'h0001_0001, 4'd3, waits);
        issue(OPC_ADD, 32'd10, 32'd20, 4'd8, waits);
        check("mul_stall_cycles", 64'(waits), 64'd32);
        idle(3);

        // Downstream stall while MUL completes: HOLD keeps the old result.
        issue(OPC_ADD, 32'd3, 32'd4, 4'd9, waits);
        no_lat = 1'b1;
        issue(OPC_MUL, 32'h1234, 32'h10, 4'd10, waits);
        no_lat = 1'b0;
        stall_i = 1'b1;
        idle(40);
        check("hold_v", {63'd0, v_o}, 64'd1);
        check("hold_res", {32'd0, result_o}, 64'd7);
        check("hold_stall", {63'd0, stall_o}, 64'd1);
        stall_i = 1'b0;
        @(posedge clk); #1;
        check("hold_release_v", {63'd0, v_o}, 64'd1);
        check("hold_release_res", {32'd0, result_o}, 64'h12340);
        idle(2);

        // NOP and an undefined opcode.
        issue(OPC_NOP, 32'hFFFF_FFFF, 32'd1, 4'd11, waits);
        issue(7'h55, 32'd9, 32'd9, 4'd12, waits);
        idle(2);

        // DIVU: iterative when enabled, undefined otherwise.
        issue(OPC_DIVU, 32'd100, 32'd7, 4'd13, waits);
        issue(OPC_DIVU, 32'd5, 32'd0, 4'd14, waits);
        idle(40);

        // Asynchronous reset mid-RUN with a valid result on the outputs.
        issue(OPC_ADD, 32'h11, 32'h22, 4'd13, waits);
        issue(OPC_MUL, 32'd5, 32'd6, 4'd14, waits);
        stall_i = 1'b1;
        idle(5);
        check("pre_reset_v", {63'd0, v_o}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check_zero("async_reset");
        sbq.delete();
        @(posedge clk); #1;
        stall_i = 1'b0;
        reset = 1'b0;
        issue(OPC_ADD, 32'h7FFF_FFFF, 32'h1, 4'd2, waits);
        check("post_reset_wait", 64'(waits), 64'd0);
        idle(40);

        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
